// File: rtl/program_counter.sv
// Program counter register for the non-pipelined RV32 core.
// Loads next-PC on enabled edges, holds on stall, and clears synchronously to the reset vector.

module program_counter #(
  parameter int unsigned Reg_size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [Reg_size-1:0] pc_next,
  output logic [Reg_size-1:0] pc_out
);

  localparam logic [Reg_size-1:0] RESET_VECTOR = '0;

  // Declaration initializer gives a defined value before the first reset edge.
  logic [Reg_size-1:0] r_pc = RESET_VECTOR;

  // Reset has priority over enable; pc_next is stored verbatim, all bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_VECTOR;
    end else if (en) begin
      r_pc <= pc_next;
    end
  end

  assign pc_out = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter.

module tb_program_counter;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] pc_next;
  logic [W-1:0] pc_out;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  program_counter #(.Reg_size(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .pc_next (pc_next),
    .pc_out  (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input logic r, input logic e, input logic [W-1:0] nxt);
    @(negedge clk);
    rst     = r;
    en      = e;
    pc_next = nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    en      = 1'b0;
    pc_next = '0;

    // Power-up: no reset ever applied, pc_out defined as 0.
    #1;
    check("powerup_t1", pc_out, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("powerup_edge1_en0", pc_out, 32'h0000_0000);

    // Sequential load 0..10.
    for (int i = 0; i <= 10; i++) begin
      step(1'b0, 1'b1, W'(i));
      check($sformatf("seq_load_%0d", i), pc_out, W'(i));
    end

    // Stall: pc_next keeps moving, pc_out frozen at 10.
    for (int i = 11; i <= 20; i++) begin
      step(1'b0, 1'b0, W'(i));
      check($sformatf("stall_%0d", i), pc_out, 32'h0000_000A);
    end

    // Reset during stall: not before the edge, 0 at the edge, held while rst=1.
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    #1;
    check("rst_stall_before_edge", pc_out, 32'h0000_000A);
    @(posedge clk);
    #1;
    check("rst_stall_edge", pc_out, 32'h0000_0000);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0000_0055);
      check($sformatf("rst_hold_%0d", i), pc_out, 32'h0000_0000);
    end

    // Reset priority over enable, then first load on the first rst=0 edge.
    step(1'b1, 1'b1, 32'h0000_1000);
    check("rst_priority", pc_out, 32'h0000_0000);
    step(1'b0, 1'b1, 32'h0000_1000);
    check("rst_release_load", pc_out, 32'h0000_1000);

    // Full-width load, exactly one edge of latency, no masking.
    @(negedge clk);
    pc_next = 32'hFFFF_FFFF;
    #1;
    check("full_before_edge", pc_out, 32'h0000_1000);
    @(posedge clk);
    #1;
    check("full_ones", pc_out, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 32'h8000_0003);
    check("full_low_bits", pc_out, 32'h8000_0003);

    // Mid-cycle pc_next change is invisible until the next edge.
    #2;
    pc_next = 32'h1234_5678;
    #1;
    check("midcycle_no_effect", pc_out, 32'h8000_0003);
    @(posedge clk);
    #1;
    check("midcycle_loaded", pc_out, 32'h1234_5678);

    // En glitch between edges is ignored; en=0 at the edge holds.
    @(negedge clk);
    en      = 1'b0;
    pc_next = 32'hDEAD_BEEC;
    #1 en = 1'b1;
    #1 en = 1'b0;
    @(posedge clk);
    #1;
    check("en_glitch_hold", pc_out, 32'h1234_5678);
    step(1'b0, 1'b1, 32'hDEAD_BEEF);
    check("en_after_glitch", pc_out, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
